rs_issue_sched: RTL and testbench
=================================

RS_ISSUE_SCHED -- requirements
Module: rs_issue_sched

Interface
REQ-001 The block SHALL have parameter RS_ENTRIES, default 8, the number of reservation-station entries tracked (power of 2, 2..16).
REQ-002 The block SHALL have parameter MUL_LAT, default 3, the non-pipelined multiplier occupancy in cycles (1..15).
REQ-003 The block SHALL have the following ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all tracked entries.
- alloc_valid  in  1  RS writes an entry this cycle.
- alloc_idx  in  log2(RS_ENTRIES)  entry written.
- alloc_is_mul  in  1  entry targets the multiplier (else ALU).
- entry_ready  in  RS_ENTRIES  per-entry operands-ready (wakeup) vector.
- alu_issue_valid  out  1  ALU issue request.
- alu_issue_idx  out  log2(RS_ENTRIES)  entry being issued to ALU.
- alu_issue_ready  in  1  ALU accepts.
- mul_issue_valid  out  1  MUL issue strobe (always accepted).
- mul_issue_idx  out  log2(RS_ENTRIES)  entry issued to MUL.
- mul_busy  out  1  multiplier occupied.
- mul_done  out  1  one-cycle pulse when MUL result is due.
- release_mask  out  RS_ENTRIES  entries freed this cycle.
- occupancy  out  log2(RS_ENTRIES)+1  count of valid entries.
- full  out  1  occupancy == RS_ENTRIES.
- alloc_err  out  1  registered pulse: alloc to an already-valid entry.

Function
REQ-004 The block SHALL hold per entry: valid, is_mul, and an RS_ENTRIES x RS_ENTRIES age matrix (older[i][j]=1 when i was allocated before j).
REQ-005 On alloc_valid with entry alloc_idx=k invalid, at the clock edge the block SHALL set valid[k], is_mul[k]=alloc_is_mul, older[k][*]=0, and older[j][k]=1 for every valid j.
REQ-006 A newly allocated entry SHALL NOT be an issue candidate until the cycle after allocation.
REQ-007 ALU candidate i: valid & ~is_mul & entry_ready[i]; MUL candidate i: valid & is_mul & entry_ready[i].
REQ-008 Selection SHALL be oldest-first: candidate i wins when no other candidate j of the same class has older[j][i]=1.
REQ-009 ALU handshake: once alu_issue_valid is high and alu_issue_ready is low, alu_issue_idx SHALL be locked and alu_issue_valid held high until acceptance, regardless of older entries becoming ready.
REQ-010 ALU issue SHALL complete in the cycle alu_issue_valid & alu_issue_ready; the entry's bit in release_mask SHALL be 1 that cycle, and valid SHALL clear at the following edge.
REQ-011 mul_issue_valid SHALL assert combinationally when a MUL candidate exists and mul_busy=0; that cycle the entry's release_mask bit SHALL be 1 and a 4-bit counter SHALL load MUL_LAT at the edge.
REQ-012 mul_busy SHALL equal (counter != 0); the counter SHALL decrement each cycle while nonzero; mul_done SHALL pulse for the single cycle in which the counter equals 1.
REQ-013 ALU and MUL issue SHALL be able to complete in the same cycle (two bits set in release_mask).
REQ-014 Alloc to a valid index SHALL be ignored and alloc_err SHALL pulse the next cycle; this includes an index being released in the same cycle (release takes effect, alloc lost).
REQ-015 occupancy SHALL be registered and equal popcount(valid); alloc and release in the same cycle SHALL net out.
REQ-016 While full=1, alloc_valid to any index SHALL produce alloc_err.
REQ-017 flush SHALL clear all valid bits, the ALU lock, and the MUL counter at the next edge; in a flush cycle alu_issue_valid, mul_issue_valid and release_mask SHALL be forced to 0 and alloc SHALL be ignored without alloc_err.
REQ-018 The lowest index SHALL win among candidates with equal age (only possible after reset/flush; defensive tiebreak).

Reset
REQ-019 rst_n low SHALL asynchronously clear valid, is_mul, age matrix, ALU lock, MUL counter and alloc_err; the outputs SHALL then read alu_issue_valid=0, mul_issue_valid=0, mul_busy=0, mul_done=0, release_mask=0, occupancy=0, full=0, alloc_err=0, with alu_issue_idx=0 and mul_issue_idx=0.
REQ-020 Reset released mid-MUL-operation SHALL produce no mul_done pulse.

Verification
REQ-021 Alloc ALU entries 5, 2, 7 in that order, all ready, alu_issue_ready=1 -> issue order 5, 2, 7 on consecutive cycles; release_mask 0x20, 0x04, 0x80.
REQ-022 Alloc ALU entry 3 ready, alu_issue_ready=0 for 4 cycles, then alloc an older-ready case is impossible; alloc entry 1 (younger) ready -> idx stays 3 until ready=1, then 3 then 1.
REQ-023 MUL entries 0 and 1 ready, MUL_LAT=3 -> issue 0 at cycle t, mul_busy t+1..t+3, mul_done at t+3, issue 1 at t+4.
REQ-024 Alloc to valid entry 4 -> alloc_err=1 the next cycle, occupancy unchanged, is_mul[4] unchanged.
REQ-025 Fill all 8 entries -> full=1, occupancy=8; assert flush during MUL busy -> next cycle occupancy=0, mul_busy=0, no mul_done.
REQ-026 Deassert rst_n asynchronously with ALU locked and MUL busy -> all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: age-matrix oldest-first pick for one
// ALU port (valid/ready with lock) and one non-pipelined multiplier.
module rs_issue_entry #(
   parameter int N = 8,
   parameter int I = 0
) (
   input  logic [N-1:0] cand_alu,
   input  logic [N-1:0] cand_mul,
   input  logic [N-1:0] older_col,
   output logic         win_alu,
   output logic         win_mul
);
   // older_col[j] = older[j][I]: entry I loses if any same-class candidate predates it
   assign win_alu = cand_alu[I] & ~|(cand_alu & older_col);
   assign win_mul = cand_mul[I] & ~|(cand_mul & older_col);
endmodule

module rs_issue_sched #(
   parameter int RS_ENTRIES = 8,
   parameter int MUL_LAT    = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          alloc_valid,
   input  logic [$clog2(RS_ENTRIES)-1:0] alloc_idx,
   input  logic                          alloc_is_mul,
   input  logic [RS_ENTRIES-1:0]         entry_ready,
   output logic                          alu_issue_valid,
   output logic [$clog2(RS_ENTRIES)-1:0] alu_issue_idx,
   input  logic                          alu_issue_ready,
   output logic                          mul_issue_valid,
   output logic [$clog2(RS_ENTRIES)-1:0] mul_issue_idx,
   output logic                          mul_busy,
   output logic                          mul_done,
   output logic [RS_ENTRIES-1:0]         release_mask,
   output logic [$clog2(RS_ENTRIES):0]   occupancy,
   output logic                          full,
   output logic                          alloc_err
);
   localparam int N  = RS_ENTRIES;
   localparam int IW = $clog2(RS_ENTRIES);

   logic [N-1:0]         valid, is_mul, valid_nxt;
   logic [N-1:0][N-1:0]  older, older_t;
   logic [N-1:0]         cand_alu, cand_mul, win_alu, win_mul;
   logic [IW-1:0]        alu_sel, mul_sel, lock_idx;
   logic                 alu_any, mul_any, lock_vld, alu_fire;
   logic                 alloc_hit, alloc_ok;
   logic [3:0]           cnt;
   logic [IW:0]          occ_nxt;

   assign cand_alu = valid & ~is_mul & entry_ready;
   assign cand_mul = valid &  is_mul & entry_ready;

   always_comb begin
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            older_t[i][j] = older[j][i];
   end

   for (genvar g = 0; g < N; g++) begin : g_ent
      rs_issue_entry #(.N(N), .I(g)) u_ent (
         .cand_alu  (cand_alu),
         .cand_mul  (cand_mul),
         .older_col (older_t[g]),
         .win_alu   (win_alu[g]),
         .win_mul   (win_mul[g])
      );
   end

   // Lowest index wins ties (only reachable with equal-age entries)
   always_comb begin
      alu_sel = '0;
      mul_sel = '0;
      alu_any = 1'b0;
      mul_any = 1'b0;
      for (int i = N-1; i >= 0; i--) begin
         if (win_alu[i]) begin alu_sel = IW'(i); alu_any = 1'b1; end
         if (win_mul[i]) begin mul_sel = IW'(i); mul_any = 1'b1; end
      end
   end

   assign alu_issue_valid = ~flush & (lock_vld | alu_any);
   assign alu_issue_idx   = lock_vld ? lock_idx : alu_sel;
   assign alu_fire        = alu_issue_valid & alu_issue_ready;
   assign mul_busy        = (cnt != 4'd0);
   assign mul_done        = (cnt == 4'd1);
   assign mul_issue_valid = ~flush & mul_any & ~mul_busy;
   assign mul_issue_idx   = mul_sel;
   assign release_mask    = (alu_fire        ? (N'(1) << alu_issue_idx) : '0)
                          | (mul_issue_valid ? (N'(1) << mul_issue_idx) : '0);
   assign full            = (occupancy == (IW+1)'(N));

   // Alloc checks the pre-edge valid, so an index being released is still "taken"
   assign alloc_hit = alloc_valid & ~flush;
   assign alloc_ok  = alloc_hit & ~valid[alloc_idx];

   always_comb begin
      valid_nxt = flush ? '0
                : (valid & ~release_mask) | (alloc_ok ? (N'(1) << alloc_idx) : '0);
      occ_nxt = '0;
      for (int i = 0; i < N; i++)
         occ_nxt = occ_nxt + (IW+1)'(valid_nxt[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid     <= '0;
         is_mul    <= '0;
         older     <= '0;
         occupancy <= '0;
         alloc_err <= 1'b0;
         lock_vld  <= 1'b0;
         lock_idx  <= '0;
         cnt       <= 4'd0;
      end else begin
         valid     <= valid_nxt;
         occupancy <= occ_nxt;
         alloc_err <= alloc_hit & valid[alloc_idx];
         if (alloc_ok) begin
            is_mul[alloc_idx] <= alloc_is_mul;
            for (int i = 0; i < N; i++) begin
               older[alloc_idx][i] <= 1'b0;
               older[i][alloc_idx] <= valid[i];
            end
         end
         if (flush || alu_fire) begin
            lock_vld <= 1'b0;
         end else if (alu_issue_valid) begin
            lock_vld <= 1'b1;
            lock_idx <= alu_issue_idx;
         end
         if (flush)                cnt <= 4'd0;
         else if (mul_issue_valid) cnt <= 4'(MUL_LAT);
         else if (cnt != 4'd0)     cnt <= cnt - 4'd1;
      end
   end
endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed table-driven bench for rs_issue_sched (RS_ENTRIES=8, MUL_LAT=3).
module tb_rs_issue_sched;
   logic       clk = 1'b0;
   logic       rst_n, flush, alloc_valid, alloc_is_mul, alu_issue_ready;
   logic [2:0] alloc_idx;
   logic [7:0] entry_ready;
   logic       alu_issue_valid, mul_issue_valid, mul_busy, mul_done, full, alloc_err;
   logic [2:0] alu_issue_idx, mul_issue_idx;
   logic [7:0] release_mask;
   logic [3:0] occupancy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rs_issue_sched #(.RS_ENTRIES(8), .MUL_LAT(3)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .alloc_is_mul(alloc_is_mul),
      .entry_ready(entry_ready),
      .alu_issue_valid(alu_issue_valid), .alu_issue_idx(alu_issue_idx),
      .alu_issue_ready(alu_issue_ready),
      .mul_issue_valid(mul_issue_valid), .mul_issue_idx(mul_issue_idx),
      .mul_busy(mul_busy), .mul_done(mul_done), .release_mask(release_mask),
      .occupancy(occupancy), .full(full), .alloc_err(alloc_err)
   );

   typedef struct {
      logic       av; logic [2:0] ai; logic am; logic [7:0] rdy; logic ar; logic fl;
      logic       e_av; logic [2:0] e_ai; logic e_mv; logic [2:0] e_mi;
      logic [7:0] e_rel; logic [3:0] e_occ; logic e_full, e_busy, e_done, e_err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic av, input int ai, input logic am,
                               input int rdy, input logic ar, input logic fl,
                               input logic eav, input int eai, input logic emv,
                               input int emi, input int erel, input int eocc,
                               input logic efull, input logic ebusy,
                               input logic edone, input logic eerr);
      vec_t v;
      v.av = av; v.ai = 3'(ai); v.am = am; v.rdy = 8'(rdy); v.ar = ar; v.fl = fl;
      v.e_av = eav; v.e_ai = 3'(eai); v.e_mv = emv; v.e_mi = 3'(emi);
      v.e_rel = 8'(erel); v.e_occ = 4'(eocc); v.e_full = efull;
      v.e_busy = ebusy; v.e_done = edone; v.e_err = eerr;
      return v;
   endfunction

   task automatic chk(input string name, input int row, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s row=%0d got=%0d expected=%0d", name, row, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".alu_valid"}, -1, alu_issue_valid, 0);
      chk({tag, ".alu_idx"},   -1, alu_issue_idx, 0);
      chk({tag, ".mul_valid"}, -1, mul_issue_valid, 0);
      chk({tag, ".mul_idx"},   -1, mul_issue_idx, 0);
      chk({tag, ".mul_busy"},  -1, mul_busy, 0);
      chk({tag, ".mul_done"},  -1, mul_done, 0);
      chk({tag, ".release"},   -1, release_mask, 0);
      chk({tag, ".occupancy"}, -1, occupancy, 0);
      chk({tag, ".full"},      -1, full, 0);
      chk({tag, ".alloc_err"}, -1, alloc_err, 0);
   endtask

   task automatic drive(input logic av, input int ai, input logic am,
                        input int rdy, input logic ar, input logic fl);
      alloc_valid = av; alloc_idx = 3'(ai); alloc_is_mul = am;
      entry_ready = 8'(rdy); alu_issue_ready = ar; flush = fl;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Oldest-first ALU: 5,2,7 allocated while not ready, then all ready
      tbl.push_back(mk(1,5,0,'h00,1,0, 0,0,0,0,'h00,0,0,0,0,0));
      tbl.push_back(mk(1,2,0,'h00,1,0, 0,0,0,0,'h00,1,0,0,0,0));
      tbl.push_back(mk(1,7,0,'h00,1,0, 0,0,0,0,'h00,2,0,0,0,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 1,5,0,0,'h20,3,0,0,0,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 1,2,0,0,'h04,2,0,0,0,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 1,7,0,0,'h80,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 0,0,0,0,'h00,0,0,0,0,0));
      // ALU lock: 3 stalled holds its slot after older entry 1 becomes ready
      tbl.push_back(mk(1,1,0,'h08,0,0, 0,0,0,0,'h00,0,0,0,0,0));
      tbl.push_back(mk(1,3,0,'h08,0,0, 0,0,0,0,'h00,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,'h08,0,0, 1,3,0,0,'h00,2,0,0,0,0));
      tbl.push_back(mk(0,0,0,'h0A,0,0, 1,3,0,0,'h00,2,0,0,0,0));
      tbl.push_back(mk(0,0,0,'h0A,0,0, 1,3,0,0,'h00,2,0,0,0,0));
      tbl.push_back(mk(0,0,0,'h0A,1,0, 1,3,0,0,'h08,2,0,0,0,0));
      tbl.push_back(mk(0,0,0,'h0A,1,0, 1,1,0,0,'h02,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,'h00,1,0, 0,0,0,0,'h00,0,0,0,0,0));
      // MUL 0,1 plus ALU 2; ALU+MUL same-cycle issue, then multiplier occupancy
      tbl.push_back(mk(1,0,1,'h00,1,0, 0,0,0,0,'h00,0,0,0,0,0));
      tbl.push_back(mk(1,1,1,'h00,1,0, 0,0,0,0,'h00,1,0,0,0,0));
      tbl.push_back(mk(1,2,0,'h00,1,0, 0,0,0,0,'h00,2,0,0,0,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 1,2,1,0,'h05,3,0,0,0,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 0,0,0,0,'h00,1,0,1,0,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 0,0,0,0,'h00,1,0,1,0,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 0,0,0,0,'h00,1,0,1,1,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 0,0,1,1,'h02,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 0,0,0,0,'h00,0,0,1,0,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 0,0,0,0,'h00,0,0,1,0,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 0,0,0,0,'h00,0,0,1,1,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 0,0,0,0,'h00,0,0,0,0,0));
      // Alloc to valid entry 4 (kept ALU), then alloc racing its release
      tbl.push_back(mk(1,4,0,'h00,1,0, 0,0,0,0,'h00,0,0,0,0,0));
      tbl.push_back(mk(1,4,1,'h00,1,0, 0,0,0,0,'h00,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,'h00,1,0, 0,0,0,0,'h00,1,0,0,0,1));
      tbl.push_back(mk(1,4,0,'h10,1,0, 1,4,0,0,'h10,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,'h00,1,0, 0,0,0,0,'h00,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,'h00,1,0, 0,0,0,0,'h00,0,0,0,0,0));
      // Fill all entries (0 is MUL), alloc while full, flush during MUL busy
      tbl.push_back(mk(1,0,1,'h00,0,0, 0,0,0,0,'h00,0,0,0,0,0));
      for (int k = 1; k < 8; k++)
         tbl.push_back(mk(1,k,0,'h00,0,0, 0,0,0,0,'h00,k,0,0,0,0));
      tbl.push_back(mk(1,2,0,'h00,0,0, 0,0,0,0,'h00,8,1,0,0,0));
      tbl.push_back(mk(0,0,0,'h01,0,0, 0,0,1,0,'h01,8,1,0,0,1));
      tbl.push_back(mk(1,0,0,'hFF,1,1, 0,0,0,0,'h00,7,0,1,0,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 0,0,0,0,'h00,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,'hFF,1,0, 0,0,0,0,'h00,0,0,0,0,0));

      for (int r = 0; r < tbl.size(); r++) begin
         @(negedge clk);
         drive(tbl[r].av, tbl[r].ai, tbl[r].am, tbl[r].rdy, tbl[r].ar, tbl[r].fl);
         #1;
         chk("alu_valid", r, alu_issue_valid, tbl[r].e_av);
         if (tbl[r].e_av) chk("alu_idx", r, alu_issue_idx, tbl[r].e_ai);
         chk("mul_valid", r, mul_issue_valid, tbl[r].e_mv);
         if (tbl[r].e_mv) chk("mul_idx", r, mul_issue_idx, tbl[r].e_mi);
         chk("release",   r, release_mask, tbl[r].e_rel);
         chk("occupancy", r, occupancy, tbl[r].e_occ);
         chk("full",      r, full, tbl[r].e_full);
         chk("mul_busy",  r, mul_busy, tbl[r].e_busy);
         chk("mul_done",  r, mul_done, tbl[r].e_done);
         chk("alloc_err", r, alloc_err, tbl[r].e_err);
      end

      // Async reset with ALU locked and MUL busy, no clock edge in between
      @(negedge clk); drive(1, 0, 1, 'h00, 0, 0);
      @(negedge clk); drive(1, 1, 0, 'h00, 0, 0);
      @(negedge clk); drive(0, 0, 0, 'h03, 0, 0);
      #1;
      chk("pre.mul_valid", -1, mul_issue_valid, 1);
      chk("pre.alu_valid", -1, alu_issue_valid, 1);
      @(negedge clk);
      #1;
      chk("pre.mul_busy", -1, mul_busy, 1);
      chk("pre.alu_lock", -1, alu_issue_valid, 1);
      drive(0, 0, 0, 'h00, 0, 0);
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("post_reset.mul_done", c, mul_done, 0);
         chk("post_reset.mul_busy", c, mul_busy, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
